sm2201_cycle_responder: RTL

Crate-side responder for the SM2201 two-strobe cycle driven by micro_program_automate.
- Decodes sel2/c1/c2/x1:x0 from the initiator.
- Performs a register read or write on a 4-entry register bank.
- Returns the cx1 acknowledge that the initiator waits on.
- Serves as the bench counterpart for the initiator and as a synthesizable slave model on the interface board.

---
 rtl/sm2201_pkg.sv | 19 +
 rtl/sm2201_strobe_sync.sv | 18 +
 rtl/sm2201_cycle_responder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sm2201_pkg.sv
// rtl/sm2201_pkg.sv - shared types and constants for the SM2201 cycle responder
package sm2201_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DELAY = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_DATA = 2'd1;
  localparam logic [1:0] REG_WCNT = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  localparam int STAT_PEND = 0;
  localparam int STAT_ERR  = 1;

endpackage

// File: rtl/sm2201_strobe_sync.sv
// rtl/sm2201_strobe_sync.sv - one-stage strobe sampler with rising-edge detect
module sm2201_strobe_sync (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic rise
);

  logic strobe_q;

  always_ff @(posedge clk) begin
    if (reset) strobe_q <= 1'b0;
    else       strobe_q <= strobe;
  end

  assign rise = strobe & ~strobe_q;

endmodule

// File: rtl/sm2201_cycle_responder.sv
// rtl/sm2201_cycle_responder.sv - SM2201 two-strobe cycle responder with 4-entry register bank
module sm2201_cycle_responder
  import sm2201_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int RESP_DELAY = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel2,
  input  logic              c1,
  input  logic              c2,
  input  logic              x0,
  input  logic              x1,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  output logic              cx1,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic              irq,
  output logic              err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t state, state_nx;

  logic              c1_rise, c2_rise;
  logic [1:0]        addr;
  logic              wr_q;
  logic [DATA_W-1:0] wdata;
  logic [TW-1:0]     tcnt;
  logic [3:0]        dcnt;

  logic [DATA_W-1:0] ctrl_r, data_r, wcnt_r;
  logic              pending, sticky;
  logic [DATA_W-1:0] rd_val;

  logic latch_addr, latch_data, commit, abort, tmo, finish;

  sm2201_strobe_sync u_c1 (.clk(clk), .reset(reset), .strobe(c1), .rise(c1_rise));
  sm2201_strobe_sync u_c2 (.clk(clk), .reset(reset), .strobe(c2), .rise(c2_rise));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Losing sel2 outranks every other event once a cycle has started.
  always_comb begin
    state_nx   = state;
    latch_addr = 1'b0;
    latch_data = 1'b0;
    commit     = 1'b0;
    abort      = 1'b0;
    tmo        = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (c1_rise && sel2) begin
          latch_addr = 1'b1;
          state_nx   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (!sel2) begin
          abort    = 1'b1;
          state_nx = ST_IDLE;
        end else if (c2_rise) begin
          latch_data = 1'b1;
          state_nx   = ST_DELAY;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          tmo      = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      ST_DELAY: begin
        if (!sel2) begin
          abort    = 1'b1;
          state_nx = ST_IDLE;
        end else if (dcnt == 4'd0) begin
          commit   = 1'b1;
          state_nx = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!sel2) begin
          abort    = 1'b1;
          state_nx = ST_IDLE;
        end else if (!c2) begin
          finish   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (addr)
      REG_CTRL: rd_val = ctrl_r;
      REG_DATA: rd_val = data_r;
      REG_WCNT: rd_val = wcnt_r;
      REG_STAT: begin
        rd_val[STAT_PEND] = pending;
        rd_val[STAT_ERR]  = sticky;
      end
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr     <= 2'd0;
      wr_q     <= 1'b0;
      wdata    <= '0;
      tcnt     <= '0;
      dcnt     <= 4'd0;
      ctrl_r   <= '0;
      data_r   <= '0;
      wcnt_r   <= '0;
      pending  <= 1'b0;
      sticky   <= 1'b0;
      cx1      <= 1'b0;
      data_oe  <= 1'b0;
      data_out <= '0;
      irq      <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= abort | tmo;
      irq <= pending & ctrl_r[0];

      if (latch_addr) begin
        addr <= {x1, x0};
        wr_q <= wr;
        tcnt <= '0;
      end else if (state == ST_ADDR) begin
        tcnt <= tcnt + TW'(1);
      end

      if (latch_data) begin
        wdata <= data_in;
        dcnt  <= 4'(RESP_DELAY - 1);
      end else if (state == ST_DELAY && dcnt != 4'd0) begin
        dcnt <= dcnt - 4'd1;
      end

      if (commit) begin
        cx1     <= 1'b1;
        data_oe <= ~wr_q;
        if (wr_q) begin
          wcnt_r <= wcnt_r + DATA_W'(1);
          if (addr == REG_CTRL) ctrl_r <= wdata;
          if (addr == REG_DATA) begin
            data_r  <= wdata;
            pending <= 1'b1;
          end
        end else begin
          data_out <= rd_val;
          if (addr == REG_STAT) begin
            pending <= 1'b0;
            sticky  <= 1'b0;
          end
        end
      end

      if (abort || finish) begin
        cx1      <= 1'b0;
        data_oe  <= 1'b0;
        data_out <= '0;
      end

      if (abort || tmo) sticky <= 1'b1;
    end
  end

endmodule
